// File: rtl/multiplication_n_digit.sv
// Sequential radix-2 shift-add multiplier: unsigned integer data0 times unsigned
// fixed-point {data1, digit}, fixed latency of n+digit RUN cycles.
module multiplication_n_digit #(
  parameter int n     = 32,
  parameter int digit = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [n-1:0]     data0_i,
  input  logic [n-1:0]     data1_i,
  input  logic [digit-1:0] digit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [n-1:0]     y_int,
  output logic [n-1:0]     y_dec,
  output logic             ovf_o
);

  localparam int W  = n + digit;
  localparam int AW = 2 * n + digit;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic            load_s;
  logic            last_s;
  logic [AW-1:0]   acc_r;
  logic [AW-1:0]   mcand_r;
  logic [W-1:0]    mult_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   acc_sum_s;
  logic [n-1:0]    dec_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; DONE accepts a new request exactly like IDLE
  always_comb begin
    next_s = state_r;
    load_s = 1'b0;
    last_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          next_s = RUN;
          load_s = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == CW'(1)) begin
          next_s = DONE;
          last_s = 1'b1;
        end else begin
          next_s = RUN;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // One shift-add step; the multiplicand is pre-shifted to the current bit weight
  always_comb begin
    acc_sum_s = acc_r + (mult_r[0] ? mcand_r : {AW{1'b0}});
  end

  // Fraction bits land in the low part of y_dec, upper bits stay zero
  always_comb begin
    dec_s              = '0;
    dec_s[digit-1:0]   = acc_sum_s[digit-1:0];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_r   <= '0;
      mcand_r <= '0;
      mult_r  <= '0;
      count_r <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      y_int   <= '0;
      y_dec   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      busy_o <= (next_s == RUN);
      done_o <= last_s;
      if (load_s) begin
        acc_r   <= '0;
        mcand_r <= AW'(data0_i);
        mult_r  <= {data1_i, digit_i};
        count_r <= CW'(W);
      end else if (state_r == RUN) begin
        acc_r   <= acc_sum_s;
        mcand_r <= mcand_r << 1;
        mult_r  <= mult_r >> 1;
        count_r <= count_r - CW'(1);
      end else begin
        acc_r <= acc_r;
      end
      if (last_s) begin
        y_int <= acc_sum_s[W-1:digit];
        y_dec <= dec_s;
        ovf_o <= |acc_sum_s[AW-1:W];
      end else begin
        y_int <= y_int;
      end
    end
  end

endmodule

// File: tb/tb_multiplication_n_digit.sv
// Randomized and directed checks of multiplication_n_digit against a plain
// arithmetic product model.
module tb_multiplication_n_digit;

  localparam int N   = 32;
  localparam int DIG = 16;
  localparam int LAT = N + DIG;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [N-1:0]   data0_i;
  logic [N-1:0]   data1_i;
  logic [DIG-1:0] digit_i;
  logic           busy_o;
  logic           done_o;
  logic [N-1:0]   y_int;
  logic [N-1:0]   y_dec;
  logic           ovf_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] exp_int;
  logic [N-1:0] exp_dec;
  logic         exp_ovf;

  multiplication_n_digit #(.n(N), .digit(DIG)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data0_i (data0_i),
    .data1_i (data1_i),
    .digit_i (digit_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_int   (y_int),
    .y_dec   (y_dec),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision product, then split into fields
  task automatic model(input logic [N-1:0] d0, input logic [N-1:0] d1, input logic [DIG-1:0] dg);
    logic [2*N+DIG-1:0] p;
    p = (2*N+DIG)'(d0) * (2*N+DIG)'({d1, dg});
    exp_int = p[N+DIG-1:DIG];
    exp_dec = N'(p[DIG-1:0]);
    exp_ovf = |p[2*N+DIG-1:N+DIG];
  endtask

  task automatic chk_results(input string tag);
    chk({tag, ".y_int"}, 64'(y_int), 64'(exp_int));
    chk({tag, ".y_dec"}, 64'(y_dec), 64'(exp_dec));
    chk({tag, ".ovf"},   64'(ovf_o), 64'(exp_ovf));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] d0, input logic [N-1:0] d1,
                        input logic [DIG-1:0] dg, input bit perturb);
    int done_at;
    int busy_cnt;
    int overlap;
    done_at  = -1;
    busy_cnt = 0;
    overlap  = 0;
    @(negedge clk_i);
    data0_i = d0; data1_i = d1; digit_i = dg; start_i = 1'b1;
    @(posedge clk_i);
    for (int m = 0; m < 100 && done_at < 0; m++) begin
      @(negedge clk_i);
      if (m == 0) start_i = 1'b0;
      if (busy_o) busy_cnt++;
      if (busy_o && done_o) overlap++;
      if (m == 10) chk({tag, ".hold"}, 64'({y_int, y_dec}), 64'({exp_int, exp_dec}));
      if (perturb && m == 5) begin
        data0_i = $urandom; data1_i = $urandom; digit_i = DIG'($urandom); start_i = 1'b1;
      end
      if (perturb && m == 7) start_i = 1'b0;
      if (done_o) done_at = m;
    end
    model(d0, d1, dg);
    chk({tag, ".latency"}, 64'(done_at), 64'(LAT));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    chk({tag, ".overlap"}, 64'(overlap), 64'(0));
    chk_results(tag);
    @(negedge clk_i);
    chk({tag, ".done_pulse"}, 64'({done_o, busy_o}), 64'(0));
  endtask

  initial begin
    int first;
    int second;
    int extra;
    int stray;
    rst_i = 1'b0; start_i = 1'b0; data0_i = '0; data1_i = '0; digit_i = '0;
    exp_int = '0; exp_dec = '0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset.outs", 64'({busy_o, done_o, ovf_o}), 64'(0));
    chk("reset.y", 64'({y_int, y_dec}), 64'(0));
    rst_i = 1'b1;

    run_op("ex_2p5", 32'd3, 32'd2, 16'h8000, 1'b0);
    chk("ex_2p5.const", 64'({y_int, y_dec}), {32'd7, 32'h0000_8000});
    run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
    chk("all_ones.ovf_const", 64'(ovf_o), 64'(1));
    run_op("frac_only", 32'd5, 32'd0, 16'h0001, 1'b0);
    chk("frac_only.const", 64'({y_int, y_dec}), {32'd0, 32'd5});
    run_op("zero_d0", 32'd0, $urandom, DIG'($urandom), 1'b0);
    run_op("zero_mult", $urandom, 32'd0, 16'h0000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = $urandom;
      b = (i % 2 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
      run_op("random", a, b, DIG'($urandom), (i % 3) != 0);
    end

    // Back-to-back with start held high; second operand set presented during RUN
    first = -1; second = -1; extra = 0;
    @(negedge clk_i);
    data0_i = 32'd11; data1_i = 32'd9; digit_i = 16'h4000; start_i = 1'b1;
    @(posedge clk_i);
    for (int m = 0; m < 120; m++) begin
      @(negedge clk_i);
      if (m == 0) begin
        data0_i = 32'h0001_2345; data1_i = 32'd300; digit_i = 16'hC000;
      end
      if (done_o) begin
        if (first < 0) begin
          first = m;
          model(32'd11, 32'd9, 16'h4000);
          chk_results("b2b.first");
        end else if (second < 0) begin
          second = m;
          start_i = 1'b0;
          model(32'h0001_2345, 32'd300, 16'hC000);
          chk_results("b2b.second");
        end else begin
          extra++;
        end
      end
    end
    start_i = 1'b0;
    chk("b2b.first_at", 64'(first), 64'(48));
    chk("b2b.second_at", 64'(second), 64'(97));
    chk("b2b.extra", 64'(extra), 64'(0));

    // Reset in the middle of RUN, with start asserted on the reset edge
    @(negedge clk_i);
    data0_i = $urandom; data1_i = $urandom; digit_i = DIG'($urandom); start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b1;
    @(negedge clk_i);
    exp_int = '0; exp_dec = '0; exp_ovf = 1'b0;
    chk("midrst.outs", 64'({busy_o, done_o, ovf_o}), 64'(0));
    chk("midrst.y", 64'({y_int, y_dec}), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b0;
    stray = 0;
    for (int m = 0; m < 60; m++) begin
      @(negedge clk_i);
      if (done_o || busy_o) stray++;
    end
    chk("midrst.no_done", 64'(stray), 64'(0));
    run_op("after_rst", 32'd4, 32'd1, 16'h4000, 1'b0);
    chk("after_rst.const", 64'({y_int, y_dec}), {32'd5, 32'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
